ram_stream_loader: RTL and testbench
====================================

# ram_stream_loader

Byte-stream writer for the CPU's two-read/one-write register-file and memory RAMs. It accepts bytes on a valid/ready stream, packs them little-endian into DATA_WIDTH-bit words, and drives the RAM write port (addr_w, data_in, we) at consecutive addresses from a programmed base. It sits between the host/UART byte source and the RAM write port, and is used for program loading and register-file initialisation before the core is released.

## Interface
- DATA_WIDTH, 32, RAM word width; must be a multiple of 8 and at least 8.
- ADDR_WIDTH, 12, RAM address width.
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that launches a transfer; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first word address; captured on an accepted start.
- word_count  in  ADDR_WIDTH+1  number of words to write; captured on an accepted start; 0 is legal.
- s_data  in  8  stream byte.
- s_valid  in  1  stream byte valid.
- s_ready  out  1  loader can accept a byte; registered.
- addr_w  out  ADDR_WIDTH  RAM write address; registered.
- data_in  out  DATA_WIDTH  RAM write data; registered.
- we  out  1  RAM write enable; registered; one-cycle pulse per word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a transfer.

## Operation
- Constant: BYTES = DATA_WIDTH/8.
- States:
  - IDLE: s_ready=0. On start=1, capture base_addr and word_count, clear the byte counter and the pack register. If word_count==0, go to DONE; otherwise go to COLLECT.
  - COLLECT: s_ready=1.
    - A byte is accepted when s_valid && s_ready. Byte k of a word (k=0..BYTES-1) goes into bits [8k+7:8k].
    - When byte BYTES-1 is accepted, go to WRITE.
    - With s_valid low, the block waits indefinitely.
  - WRITE: s_ready=0; we=1 for this single cycle with addr_w = current address and data_in = packed word.
    - The address increments modulo 2^ADDR_WIDTH (0xFFF wraps to 0x000).
    - The remaining count decrements. If it reaches 0, go to DONE; otherwise go to COLLECT.
  - DONE: done=1 for one cycle, then go to IDLE.
- start outside IDLE is ignored and has no side effects.
- Bytes presented while s_ready=0 are not consumed; the source must hold them.
- Reset in any state:
  - next cycle, state is IDLE;
  - s_ready, we, busy, done = 0;
  - addr_w, data_in = 0;
  - the partial word is discarded and no write is issued.

## Timing
- Reset values: every output is 0.
- The start pulse at cycle T sets busy=1 and s_ready=1 at T+1, or done=1 at T+1 if word_count==0.
- The last byte of a word accepted at cycle N gives we=1 at N+1 and s_ready=1 again at N+2.
- Minimum cost per word is BYTES+1 cycles (5 cycles at DATA_WIDTH=32).
- The final write's we at cycle W gives done=1 at W+1 and busy=0 at W+2.
- addr_w and data_in hold their values after the write until the next write or reset. Only we qualifies them.

## Structure
- Shared package ram_stream_loader_pkg holds:
  - the state enum (IDLE, COLLECT, WRITE, DONE);
  - the BYTES derivation function;
  - the word_count width helper (ADDR_WIDTH+1).
- One sub-module, byte_word_packer:
  - inputs: clear, byte-accept strobe, byte;
  - outputs: the packed word and a last_byte flag.
- The FSM, address counter and remaining counter live in the top module.

## Test plan
- Single word: DATA_WIDTH=32, base 0x010, count 1, bytes 0x11,0x22,0x33,0x44 back-to-back -> exactly one we with addr_w=0x010, data_in=0x44332211, one cycle after the 0x44 handshake; done one cycle later.
- Throttled multi-word: count 3, base 0x100, s_valid toggled randomly -> writes to 0x100, 0x101, 0x102 in order with the correct words; s_ready is low in every WRITE cycle and no bytes are lost or duplicated.
- Wrap and zero count:
  - base 0xFFF, count 2 -> writes to 0xFFF then 0x000;
  - count 0 -> no we, and done one cycle after start.
- Ignored start: pulse start with base 0x200 mid-transfer -> the original address sequence is unchanged and no extra done is produced.
- Reset mid-word: reset after 2 of 4 bytes -> all outputs 0 next cycle and no we. A new start at base 0x020 followed by 0xAA,0xBB,0xCC,0xDD writes 0xDDCCBBAA to 0x020, with no stale bytes.

Source files
------------

// File: rtl/ram_stream_loader_pkg.sv
// Shared types and width helpers for the RAM byte-stream loader.
// Covers the FSM state encoding, bytes-per-word and the word_count width.
package ram_stream_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_e;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    // word_count is one bit wider than an address so a full RAM fill is expressible
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/ram_stream_loader_byte_word_packer.sv
// Little-endian byte-to-word packer: byte k of a word lands in bits [8k+7:8k].
// The word output already contains the byte being accepted this cycle.
module byte_word_packer
    import ram_stream_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [7:0]            byte_data,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  last_byte
);

    localparam int BYTES = bytes_per_word(DATA_WIDTH);
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [DATA_WIDTH-1:0] word_r;
    logic [DATA_WIDTH-1:0] word_s;
    logic [IDX_W-1:0]      idx_r;

    // Merge the incoming byte into its lane
    always_comb begin
        word_s = word_r;
        for (int k = 0; k < BYTES; k++) begin
            if (accept && (idx_r == IDX_W'(k))) begin
                word_s[8*k +: 8] = byte_data;
            end else begin
                word_s[8*k +: 8] = word_r[8*k +: 8];
            end
        end
    end

    // Byte lane index and partial word storage
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word_r <= {DATA_WIDTH{1'b0}};
            idx_r  <= {IDX_W{1'b0}};
        end else if (accept) begin
            if (last_byte) begin
                word_r <= {DATA_WIDTH{1'b0}};
                idx_r  <= {IDX_W{1'b0}};
            end else begin
                word_r <= word_s;
                idx_r  <= idx_r + IDX_W'(1);
            end
        end else begin
            word_r <= word_r;
            idx_r  <= idx_r;
        end
    end

    assign word      = word_s;
    assign last_byte = (idx_r == IDX_W'(BYTES - 1));

endmodule

// File: rtl/ram_stream_loader.sv
// Byte-stream RAM loader: packs stream bytes into words and writes them to
// consecutive RAM addresses starting at a programmed base.
module ram_stream_loader
    import ram_stream_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [ADDR_WIDTH-1:0]               base_addr,
    input  logic [count_width(ADDR_WIDTH)-1:0]  word_count,
    input  logic [7:0]                          s_data,
    input  logic                                s_valid,
    output logic                                s_ready,
    output logic [ADDR_WIDTH-1:0]               addr_w,
    output logic [DATA_WIDTH-1:0]               data_in,
    output logic                                we,
    output logic                                busy,
    output logic                                done
);

    localparam int CW = count_width(ADDR_WIDTH);

    state_e                state_r;
    state_e                next_state_s;
    logic [ADDR_WIDTH-1:0] addr_cnt_r;
    logic [CW-1:0]         remaining_r;
    logic [ADDR_WIDTH-1:0] addr_w_r;
    logic [DATA_WIDTH-1:0] data_in_r;
    logic                  s_ready_r;
    logic                  we_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  accept_s;
    logic                  launch_s;
    logic                  last_byte_s;
    logic [DATA_WIDTH-1:0] packed_word_s;

    assign accept_s = s_valid & s_ready_r;

    byte_word_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (launch_s),
        .accept    (accept_s),
        .byte_data (s_data),
        .word      (packed_word_s),
        .last_byte (last_byte_s)
    );

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        launch_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    launch_s = 1'b1;
                    if (word_count == CW'(0)) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = COLLECT;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            COLLECT: begin
                if (accept_s && last_byte_s) begin
                    next_state_s = WRITE;
                end else begin
                    next_state_s = COLLECT;
                end
            end
            WRITE: begin
                if (remaining_r == CW'(1)) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = COLLECT;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Address and remaining-word counters; start outside IDLE never reaches here
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_cnt_r  <= {ADDR_WIDTH{1'b0}};
            remaining_r <= {CW{1'b0}};
        end else if (launch_s) begin
            addr_cnt_r  <= base_addr;
            remaining_r <= word_count;
        end else if (state_r == WRITE) begin
            addr_cnt_r  <= addr_cnt_r + ADDR_WIDTH'(1);
            remaining_r <= remaining_r - CW'(1);
        end else begin
            addr_cnt_r  <= addr_cnt_r;
            remaining_r <= remaining_r;
        end
    end

    // Outputs registered from the next state so they align with the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            s_ready_r <= 1'b0;
            we_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            addr_w_r  <= {ADDR_WIDTH{1'b0}};
            data_in_r <= {DATA_WIDTH{1'b0}};
        end else begin
            s_ready_r <= (next_state_s == COLLECT);
            we_r      <= (next_state_s == WRITE);
            busy_r    <= (next_state_s != IDLE);
            done_r    <= (next_state_s == DONE);
            if (next_state_s == WRITE) begin
                addr_w_r  <= addr_cnt_r;
                data_in_r <= packed_word_s;
            end else begin
                addr_w_r  <= addr_w_r;
                data_in_r <= data_in_r;
            end
        end
    end

    assign s_ready = s_ready_r;
    assign we      = we_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign addr_w  = addr_w_r;
    assign data_in = data_in_r;

endmodule

// File: tb/tb_ram_stream_loader.sv
// Scoreboard bench for ram_stream_loader: expected RAM writes are derived from
// the byte list and queued; a negedge monitor pops them on every we pulse.
module tb_ram_stream_loader;

    localparam int TB_BYTES = 4;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] word_count;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [11:0] addr_w;
    logic [31:0] data_in;
    logic        we;
    logic        busy;
    logic        done;

    wr_t        exp_q[$];
    logic [7:0] stim_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_seen = 0;
    int         done_exp  = 0;

    ram_stream_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .addr_w     (addr_w),
        .data_in    (data_in),
        .we         (we),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference: word w is bytes 4w..4w+3 little-endian, address base+w modulo 4096
    task automatic expect_transfer(input int base, input int cnt);
        wr_t rec;
        for (int w = 0; w < cnt; w++) begin
            longint word = 0;
            for (int k = 0; k < TB_BYTES; k++) begin
                word = word + (longint'(stim_q[TB_BYTES*w + k]) << (8*k));
            end
            rec.addr = 12'((base + w) % 4096);
            rec.data = 32'(word);
            exp_q.push_back(rec);
        end
    endtask

    task automatic make_bytes(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_we"},      we,      0);
        check({tag, "_busy"},    busy,    0);
        check({tag, "_done"},    done,    0);
        check({tag, "_addr_w"},  addr_w,  0);
        check({tag, "_data_in"}, data_in, 0);
    endtask

    // Enters and leaves aligned 1 time unit after a rising edge
    task automatic do_start(input logic [11:0] b, input logic [12:0] c, input bit completes);
        base_addr  = b;
        word_count = c;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (completes) done_exp++;
        @(negedge clk);
        if (c == 13'd0) begin
            check("zero_done_next", done, 1);
            check("zero_no_we", we, 0);
        end else begin
            check("start_busy", busy, 1);
            check("start_s_ready", s_ready, 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_bytes(input bit throttle);
        int  i = 0;
        int  budget = 0;
        bit  hs;
        while (i < stim_q.size()) begin
            s_data  = stim_q[i];
            s_valid = throttle ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk); #1;
            if (hs) i++;
            budget++;
            if (budget > 2000) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", got, 1);
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
        if (we === 1'b1) begin
            check("write_s_ready_low", s_ready, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", addr_w, e.addr);
                check("write_data", data_in, e.data);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int b;
        reset = 1'b1; start = 1'b0; base_addr = 12'h000; word_count = 13'd0;
        s_data = 8'h00; s_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Single word, back-to-back bytes
        stim_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        expect_transfer(12'h010, 1);
        do_start(12'h010, 13'd1, 1'b1);
        send_bytes(1'b0);
        @(negedge clk);
        check("t1_we_latency", we, 1);
        check("t1_data_const", data_in, 32'h44332211);
        @(negedge clk);
        check("t1_done", done, 1);
        check("t1_we_single", we, 0);
        @(negedge clk);
        check("t1_busy_off", busy, 0);
        @(posedge clk); #1;

        // Throttled three words, with an ignored start mid-transfer
        make_bytes(12);
        expect_transfer(12'h100, 3);
        do_start(12'h100, 13'd3, 1'b1);
        fork
            send_bytes(1'b1);
            begin
                repeat (6) @(posedge clk);
                #1;
                base_addr = 12'h200; word_count = 13'd5; start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        wait_done();

        // Address wrap
        make_bytes(8);
        expect_transfer(12'hFFF, 2);
        do_start(12'hFFF, 13'd2, 1'b1);
        send_bytes(1'b1);
        wait_done();

        // Zero count
        do_start(12'h055, 13'd0, 1'b1);
        @(negedge clk);
        check("zero_done_pulse", done, 0);
        check("zero_busy_off", busy, 0);
        @(posedge clk); #1;

        // Randomized transfers
        for (int r = 0; r < 4; r++) begin
            cnt = $urandom_range(1, 3);
            b   = $urandom_range(0, 4095);
            make_bytes(cnt * TB_BYTES);
            expect_transfer(b, cnt);
            do_start(12'(b), 13'(cnt), 1'b1);
            send_bytes(1'b1);
            wait_done();
        end

        // Reset after two bytes discards the partial word
        stim_q = '{8'h5A, 8'hA5};
        do_start(12'h300, 13'd1, 1'b0);
        send_bytes(1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        @(posedge clk); #1;
        stim_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        expect_transfer(12'h020, 1);
        do_start(12'h020, 13'd1, 1'b1);
        send_bytes(1'b0);
        @(negedge clk);
        check("post_reset_we", we, 1);
        check("post_reset_data", data_in, 32'hDDCCBBAA);
        @(posedge clk); #1;
        wait_done();

        repeat (5) @(posedge clk);
        check("pending_writes", exp_q.size(), 0);
        check("done_count", done_seen, done_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
